carregador_instrucao: RTL and testbench

Serial loader that fills the processor's instruction memory from a byte stream instead of fixed contents. It accepts bytes over a valid/ready handshake and assembles them MSB-first into 32-bit instruction words. Each word is written sequentially from address 0 through a single-cycle write strobe. A trailing XOR checksum byte validates the transfer. It sits between the board-level byte source (UART receiver or switch interface) and the write port of the instruction memory, and holds the CPU off while loading.

---
 rtl/carregador_instrucao_if.sv | 25 ++
 rtl/carregador_instrucao.sv | 128 ++++++++++++
 tb/tb_carregador_instrucao.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_instrucao_if.sv
// Byte-stream and instruction-memory write bus of the instruction loader.
// The loader side is the slave; the byte source / memory / CPU side is the master.
interface carregador_instrucao_if;
    logic        inicio;
    logic [6:0]  num_palavras;
    logic [7:0]  byte_dado;
    logic        byte_valido;
    logic        byte_pronto;
    logic        mem_escrita;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dado;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    modport master (
        output inicio, num_palavras, byte_dado, byte_valido,
        input  byte_pronto, mem_escrita, mem_endereco, mem_dado, ocupado, concluido, erro
    );

    modport slave (
        input  inicio, num_palavras, byte_dado, byte_valido,
        output byte_pronto, mem_escrita, mem_endereco, mem_dado, ocupado, concluido, erro
    );
endinterface

// File: rtl/carregador_instrucao.sv
// Serial instruction loader: packs bytes MSB-first into 32-bit words, writes them from
// address 0 upward, then checks a trailing XOR checksum byte.
module carregador_instrucao #(
    parameter int PROFUNDIDADE = 71
) (
    input  logic                  clock,
    input  logic                  reset,
    carregador_instrucao_if.slave barramento
);
    typedef enum logic [1:0] {OCIOSO, RECEBE, ESCREVE, CHECKSUM} estado_t;

    localparam logic [6:0] MAXIMO = 7'(PROFUNDIDADE);

    estado_t     estado;
    estado_t     proximo;
    logic [6:0]  contagem;
    logic [6:0]  endereco;
    logic [1:0]  contador_bytes;
    logic [7:0]  soma;
    logic [23:0] parcial;
    logic [31:0] dado_saida;
    logic [31:0] endereco_saida;
    logic        concluido_q;
    logic        erro_q;
    logic        pronto;
    logic        escrita;
    logic        transferencia;
    logic        contagem_legal;
    logic        ultima_palavra;

    assign transferencia  = barramento.byte_valido && pronto;
    assign contagem_legal = (barramento.num_palavras != 7'd0) && (barramento.num_palavras <= MAXIMO);
    assign ultima_palavra = (endereco + 7'd1) == contagem;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= proximo;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        proximo = estado;
        pronto  = 1'b0;
        escrita = 1'b0;
        case (estado)
            OCIOSO: begin
                if (barramento.inicio && contagem_legal) proximo = RECEBE;
            end
            RECEBE: begin
                pronto = 1'b1;
                if (transferencia && contador_bytes == 2'd3) proximo = ESCREVE;
            end
            ESCREVE: begin
                escrita = 1'b1;
                proximo = ultima_palavra ? CHECKSUM : RECEBE;
            end
            CHECKSUM: begin
                pronto = 1'b1;
                if (transferencia) proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    // The 4th byte bypasses the partial buffer so the write port holds a stable word
    // while the next word is being assembled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            contagem       <= '0;
            endereco       <= '0;
            contador_bytes <= '0;
            soma           <= '0;
            parcial        <= '0;
            dado_saida     <= '0;
            endereco_saida <= '0;
            concluido_q    <= 1'b0;
            erro_q         <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (barramento.inicio) begin
                        concluido_q <= 1'b0;
                        if (contagem_legal) begin
                            contagem       <= barramento.num_palavras;
                            endereco       <= '0;
                            contador_bytes <= '0;
                            soma           <= '0;
                            erro_q         <= 1'b0;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end
                end
                RECEBE: begin
                    if (transferencia) begin
                        contador_bytes <= contador_bytes + 2'd1;
                        soma           <= soma ^ barramento.byte_dado;
                        if (contador_bytes == 2'd3) begin
                            dado_saida     <= {parcial, barramento.byte_dado};
                            endereco_saida <= {25'd0, endereco};
                        end else begin
                            parcial <= {parcial[15:0], barramento.byte_dado};
                        end
                    end
                end
                ESCREVE: begin
                    endereco <= endereco + 7'd1;
                end
                CHECKSUM: begin
                    if (transferencia) begin
                        if (barramento.byte_dado == soma) concluido_q <= 1'b1;
                        else                              erro_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign barramento.byte_pronto  = pronto;
    assign barramento.mem_escrita  = escrita;
    assign barramento.mem_endereco = endereco_saida;
    assign barramento.mem_dado     = dado_saida;
    assign barramento.ocupado      = (estado != OCIOSO);
    assign barramento.concluido    = concluido_q;
    assign barramento.erro         = erro_q;
endmodule

// File: tb/tb_carregador_instrucao.sv
// Directed bench for carregador_instrucao: inputs change on falling edges, a monitor
// logs accepted bytes and memory strobes just after each falling edge.
module tb_carregador_instrucao;
    logic clock;
    logic reset;

    carregador_instrucao_if bar();

    carregador_instrucao #(.PROFUNDIDADE(71)) dut (
        .clock      (clock),
        .reset      (reset),
        .barramento (bar)
    );

    int checks = 0;
    int errors = 0;
    int bytes_aceitos = 0;
    logic [31:0] end_log[$];
    logic [31:0] dado_log[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always begin
        @(negedge clock);
        #2;
        if (bar.byte_valido && bar.byte_pronto) bytes_aceitos++;
        if (bar.mem_escrita) begin
            end_log.push_back(bar.mem_endereco);
            dado_log.push_back(bar.mem_dado);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        end_log.delete();
        dado_log.delete();
        bytes_aceitos = 0;
    endtask

    // Called on a falling edge; returns on the falling edge of the cycle after the start edge.
    task automatic start(input logic [6:0] n);
        bar.inicio       = 1'b1;
        bar.num_palavras = n;
        @(negedge clock);
        bar.inicio = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge of the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        bar.byte_dado   = b;
        bar.byte_valido = 1'b1;
        n = 0;
        while (!bar.byte_pronto && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte %02h never accepted", b);
        end
        @(negedge clock);
        bar.byte_valido = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bar.inicio       = 1'b0;
        bar.num_palavras = 7'd0;
        bar.byte_dado    = 8'd0;
        bar.byte_valido  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bar.byte_pronto !== 1'b0) begin errors++; $display("FAIL reset_byte_pronto got %b want 0", bar.byte_pronto); end
        checks++; if (bar.mem_escrita !== 1'b0) begin errors++; $display("FAIL reset_mem_escrita got %b want 0", bar.mem_escrita); end
        checks++; if (bar.mem_endereco !== 32'd0) begin errors++; $display("FAIL reset_mem_endereco got %h want 0", bar.mem_endereco); end
        checks++; if (bar.mem_dado !== 32'd0) begin errors++; $display("FAIL reset_mem_dado got %h want 0", bar.mem_dado); end
        checks++; if (bar.ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", bar.ocupado); end
        checks++; if (bar.concluido !== 1'b0) begin errors++; $display("FAIL reset_concluido got %b want 0", bar.concluido); end
        checks++; if (bar.erro !== 1'b0) begin errors++; $display("FAIL reset_erro got %b want 0", bar.erro); end
    endtask

    task automatic test_reset_mid_word();
        clear_log();
        start(7'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bar.ocupado !== 1'b0) begin errors++; $display("FAIL midreset_ocupado got %b want 0", bar.ocupado); end
        checks++; if (bar.byte_pronto !== 1'b0) begin errors++; $display("FAIL midreset_byte_pronto got %b want 0", bar.byte_pronto); end
        checks++; if (end_log.size() !== 0) begin errors++; $display("FAIL midreset_strobes got %0d want 0", end_log.size()); end
        checks++; if (bar.mem_dado !== 32'd0 || bar.mem_endereco !== 32'd0) begin errors++; $display("FAIL midreset_mem got %h/%h want 0/0", bar.mem_endereco, bar.mem_dado); end
        checks++; if (bar.concluido !== 1'b0 || bar.erro !== 1'b0) begin errors++; $display("FAIL midreset_flags got %b%b want 00", bar.concluido, bar.erro); end
    endtask

    task automatic test_single_word();
        clear_log();
        start(7'd1);
        checks++; if (bar.ocupado !== 1'b1 || bar.byte_pronto !== 1'b1) begin errors++; $display("FAIL single_start ocupado/pronto got %b%b want 11", bar.ocupado, bar.byte_pronto); end
        send_word(32'h64010001);
        checks++; if (bar.mem_escrita !== 1'b1 || bar.byte_pronto !== 1'b0) begin errors++; $display("FAIL single_strobe escrita/pronto got %b%b want 10", bar.mem_escrita, bar.byte_pronto); end
        checks++; if (bar.mem_endereco !== 32'd0 || bar.mem_dado !== 32'h64010001) begin errors++; $display("FAIL single_strobe_data got %h/%h want 0/64010001", bar.mem_endereco, bar.mem_dado); end
        send_byte(8'h64);
        checks++; if (bar.concluido !== 1'b1 || bar.erro !== 1'b0) begin errors++; $display("FAIL single_done concluido/erro got %b%b want 10", bar.concluido, bar.erro); end
        checks++; if (bar.ocupado !== 1'b0 || bar.byte_pronto !== 1'b0) begin errors++; $display("FAIL single_idle ocupado/pronto got %b%b want 00", bar.ocupado, bar.byte_pronto); end
        checks++; if (end_log.size() !== 1 || bytes_aceitos !== 5) begin errors++; $display("FAIL single_counts strobes %0d bytes %0d want 1 5", end_log.size(), bytes_aceitos); end
    endtask

    task automatic test_illegal_count();
        clear_log();
        start(7'd0);
        checks++; if (bar.erro !== 1'b1 || bar.concluido !== 1'b0) begin errors++; $display("FAIL illegal0 erro/concluido got %b%b want 10", bar.erro, bar.concluido); end
        checks++; if (bar.ocupado !== 1'b0 || bar.byte_pronto !== 1'b0) begin errors++; $display("FAIL illegal0_idle ocupado/pronto got %b%b want 00", bar.ocupado, bar.byte_pronto); end
        start(7'd72);
        checks++; if (bar.erro !== 1'b1 || bar.ocupado !== 1'b0) begin errors++; $display("FAIL illegal72 erro/ocupado got %b%b want 10", bar.erro, bar.ocupado); end
        checks++; if (end_log.size() !== 0) begin errors++; $display("FAIL illegal_strobes got %0d want 0", end_log.size()); end
        start(7'd1);
        checks++; if (bar.erro !== 1'b0 || bar.ocupado !== 1'b1) begin errors++; $display("FAIL illegal_recover erro/ocupado got %b%b want 01", bar.erro, bar.ocupado); end
        send_word(32'h12345678);
        send_byte(8'h08);
        checks++; if (bar.concluido !== 1'b1 || bar.erro !== 1'b0) begin errors++; $display("FAIL illegal_recover_done got %b%b want 10", bar.concluido, bar.erro); end
    endtask

    task automatic test_three_words(input logic [7:0] soma, input logic bom);
        logic [31:0] palavras [3];
        palavras[0] = 32'h00000000;
        palavras[1] = 32'h64010001;
        palavras[2] = 32'hFC000008;
        clear_log();
        start(7'd3);
        for (int i = 0; i < 3; i++) send_word(palavras[i]);
        send_byte(soma);
        checks++; if (end_log.size() !== 3) begin errors++; $display("FAIL three_strobes got %0d want 3", end_log.size()); end
        for (int i = 0; i < 3 && i < end_log.size(); i++) begin
            checks++;
            if (end_log[i] !== 32'(i) || dado_log[i] !== palavras[i]) begin
                errors++;
                $display("FAIL three_write%0d got %h/%h want %h/%h", i, end_log[i], dado_log[i], i, palavras[i]);
            end
        end
        checks++; if (bar.concluido !== bom || bar.erro !== !bom) begin errors++; $display("FAIL three_flags concluido/erro got %b%b want %b%b", bar.concluido, bar.erro, bom, !bom); end
        checks++; if (bar.mem_endereco !== 32'd2 || bar.mem_dado !== 32'hFC000008) begin errors++; $display("FAIL three_hold got %h/%h want 2/fc000008", bar.mem_endereco, bar.mem_dado); end
    endtask

    task automatic test_full_depth();
        logic [7:0]  fluxo [285];
        logic [7:0]  acc;
        logic [31:0] esperado;
        int idx;
        int ciclos;
        int ruins;
        acc = 8'd0;
        for (int i = 0; i < 284; i++) begin
            fluxo[i] = 8'($urandom);
            acc ^= fluxo[i];
        end
        fluxo[284] = acc;
        clear_log();
        start(7'd71);
        idx    = 0;
        ciclos = 0;
        bar.byte_valido  = 1'b1;
        bar.num_palavras = 7'd3;
        while (idx < 285 && ciclos < 1000) begin
            bar.byte_dado = fluxo[idx];
            bar.inicio    = (ciclos % 37 == 5);
            if (bar.byte_pronto) idx++;
            ciclos++;
            @(negedge clock);
        end
        bar.inicio    = 1'b0;
        bar.byte_dado = 8'h5A;
        repeat (5) @(negedge clock);
        checks++; if (ciclos !== 356) begin errors++; $display("FAIL full_cycles got %0d want 356", ciclos); end
        checks++; if (bytes_aceitos !== 285) begin errors++; $display("FAIL full_bytes got %0d want 285", bytes_aceitos); end
        checks++; if (bar.byte_pronto !== 1'b0 || bar.ocupado !== 1'b0) begin errors++; $display("FAIL full_idle pronto/ocupado got %b%b want 00", bar.byte_pronto, bar.ocupado); end
        checks++; if (end_log.size() !== 71) begin errors++; $display("FAIL full_strobes got %0d want 71", end_log.size()); end
        ruins = 0;
        for (int i = 0; i < 71 && i < end_log.size(); i++) begin
            esperado = {fluxo[4*i], fluxo[4*i+1], fluxo[4*i+2], fluxo[4*i+3]};
            if (end_log[i] !== 32'(i) || dado_log[i] !== esperado) begin
                ruins++;
                if (ruins < 4) $display("FAIL full_write%0d got %h/%h want %h/%h", i, end_log[i], dado_log[i], i, esperado);
            end
        end
        checks++; if (ruins !== 0) begin errors++; $display("FAIL full_writes bad words %0d want 0", ruins); end
        checks++; if (bar.mem_endereco !== 32'd70) begin errors++; $display("FAIL full_last_addr got %h want 46", bar.mem_endereco); end
        checks++; if (bar.concluido !== 1'b1 || bar.erro !== 1'b0) begin errors++; $display("FAIL full_flags concluido/erro got %b%b want 10", bar.concluido, bar.erro); end
        bar.byte_valido = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_reset_mid_word();
        test_single_word();
        test_illegal_count();
        test_three_words(8'h90, 1'b1);
        test_three_words(8'h99, 1'b0);
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
